// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-port memory arbiter.
// State encoding, owner indices, op and size codes.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RELEASE
  } state_e;

  localparam int OWN_IF = 0;
  localparam int OWN_D  = 1;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter.
// slave = arbiter view, master = surrounding logic view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);

  logic              if_start;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic              d_start;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_op;
  logic [1:0]        d_size;
  logic              d_done;
  logic [DATA_W-1:0] rdata;
  logic              mem_start;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_op;
  logic [1:0]        mem_size;
  logic              mem_done;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        grant;
  logic              err;

  modport slave (
    input  if_start, if_addr,
    input  d_start, d_addr, d_wdata,
    input  d_op, d_size,
    input  mem_done, mem_rdata,
    output if_done, d_done, rdata,
    output mem_start, mem_addr,
    output mem_wdata, mem_op, mem_size,
    output grant, err
  );

  modport master (
    output if_start, if_addr,
    output d_start, d_addr, d_wdata,
    output d_op, d_size,
    output mem_done, mem_rdata,
    input  if_done, d_done, rdata,
    input  mem_start, mem_addr,
    input  mem_wdata, mem_op, mem_size,
    input  grant, err
  );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin picker; the pointer
// flips only when both ports contend.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // ptr_q = 1 favours the data port
  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt = req;
    if (&req) begin
      gnt = ptr_q ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && (&req)) begin
      ptr_d = ~ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b1;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data requests onto one memory port.
// MEM_ARB_TIMEOUT_EN adds a BUSY watchdog and sticky err.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  state_e            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              op_q, op_d;
  logic [1:0]        size_q, size_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [1:0] req;
  logic [1:0] gnt;
  logic       advance;

  assign req = {bus.d_start, bus.if_start};

  rr_arb2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (advance),
    .gnt     (gnt)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    size_d  = size_q;
    rdata_d = rdata_q;
    advance = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        advance = 1'b1;
        if (|gnt) begin
          grant_d = gnt;
          state_d = BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
          if (gnt[OWN_D]) begin
            addr_d  = bus.d_addr;
            wdata_d = bus.d_wdata;
            op_d    = bus.d_op;
            size_d  = bus.d_size;
          end else begin
            addr_d  = bus.if_addr;
            wdata_d = '0;
            op_d    = OP_LOAD;
            size_d  = SZ_W;
          end
        end
      end
      BUSY: begin
        if (bus.mem_done) begin
          state_d = RELEASE;
          if (op_q == OP_STORE) begin
            rdata_d = '0;
          end else begin
            rdata_d = bus.mem_rdata;
          end
`ifdef MEM_ARB_TIMEOUT_EN
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELEASE;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      RELEASE: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= 1'b0;
      size_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
      size_q  <= size_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.mem_start = (state_q == BUSY);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_op    = op_q;
  assign bus.mem_size  = size_q;
  assign bus.grant     = grant_q;
  assign bus.rdata     = rdata_q;
  assign bus.if_done   =
    (state_q == RELEASE) && grant_q[OWN_IF];
  assign bus.d_done    =
    (state_q == RELEASE) && grant_q[OWN_D];

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port between two requesters: instruction fetch (port 0) and data load/store (port 1).
- Each requester uses the level start / done-pulse handshake that the control unit already uses with memory: start is held high until done, then dropped.
- Sits between the control-unit memory signals and the memory model/controller. It serialises accesses, registers the granted request, and returns read data and completion to the owner.

Parameters:
- ADDR_W, 64, address width of all address ports.
- DATA_W, 64, read/write data width.
- TIMEOUT_CYCLES, 255, BUSY cycles before abort (used only with the optional feature); must be at least 1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- if_start  in  1  fetch request (level, held until if_done)
- if_addr  in  ADDR_W  fetch address; size is always word (2'b10); op is always read
- if_done  out  1  one-cycle completion pulse for fetch
- d_start  in  1  data request (level, held until d_done)
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_op  in  1  0 = load, 1 = store
- d_size  in  2  00 = B, 01 = H, 10 = W, 11 = D
- d_done  out  1  one-cycle completion pulse for data
- rdata  out  DATA_W  registered read data; valid when if_done or d_done is high
- mem_start  out  1  level request to memory
- mem_addr  out  ADDR_W  registered granted address
- mem_wdata  out  DATA_W  registered granted store data
- mem_op  out  1  registered granted operation
- mem_size  out  2  registered granted size
- mem_done  in  1  memory completion
- mem_rdata  in  DATA_W  memory read data; valid with mem_done
- grant  out  2  one-hot owner; 00 when idle
- err  out  1  sticky timeout flag; tied 0 without the optional feature

Behaviour:
- Reset: state IDLE, all outputs 0, round-robin pointer gives priority to data.
- A reset that lands mid-access drops mem_start on the next edge and produces no done pulse. The memory side aborts on mem_start low.
- States:
  - IDLE: sample the start inputs.
    - If only one start is high, latch that request into the mem_* registers, set grant, go to BUSY.
    - If both are high, grant the port the pointer favours, then flip the pointer to favour the other port.
    - A single grant does not change the pointer.
    - mem_done while IDLE is ignored.
  - BUSY: mem_start = 1 and grant is held.
    - mem_* outputs and grant are frozen; requester input changes are ignored.
    - On mem_done: capture mem_rdata into rdata (zero for a store), go to RELEASE.
  - RELEASE: lasts exactly one cycle.
    - Assert the owner's done and clear mem_start; grant still shows the owner.
    - Start inputs are ignored here, so the requester has this cycle to drop its start.
    - Next state is IDLE, with grant cleared on entry.
- Latency:
  - start seen high at edge N, so BUSY from cycle N+1.
  - mem_done sampled at edge M, so done high in cycle M+1.
  - New arbitration happens no earlier than edge M+2.
  - Minimum turnaround is 3 cycles with zero-wait memory (mem_done in the first BUSY cycle).
- rdata holds its value until the next completion.
- A new request arriving while BUSY waits; nothing is queued beyond the held level start.
- Starvation-free when both ports request continuously: grants alternate.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to BUSY and increments every BUSY cycle.
  - When it reaches TIMEOUT_CYCLES without mem_done, go to RELEASE anyway with rdata = 0 and err set.
  - err is sticky until reset.
- Without the macro: BUSY waits indefinitely, err is constant 0, and no counter logic exists.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum (IDLE, BUSY, RELEASE);
  - owner encoding (OWN_IF = 0, OWN_D = 1);
  - op constants (OP_LOAD, OP_STORE);
  - size constants (SZ_B, SZ_H, SZ_W, SZ_D).
- Sub-module rr_arb2: 2-way round-robin pick plus pointer update.
  - Inputs: req[1:0], advance.
  - Output: one-hot gnt.
- All state, capture and timeout logic stays in mem_port_arbiter.

Test Plan:
- Fetch only:
  - Stimulus: if_addr = 0x100; mem_done 2 cycles after mem_start.
  - Required: mem_addr = 0x100, mem_size = 10, mem_op = 0; if_done pulses once with rdata = mem_rdata (0x00000013); grant 01 to 00.
- Simultaneous from reset:
  - Stimulus: both starts high in the same cycle.
  - Required: data granted first; fetch granted on the next arbitration; continuous dual requests alternate D, IF, D, IF over 4 grants.
- Store:
  - Stimulus: d_op = 1, d_size = 11, d_wdata = 0xDEADBEEFCAFEF00D, d_addr = 0x2000.
  - Required: mem_* carry these values through BUSY; d_done pulses; rdata = 0.
- Input change while BUSY:
  - Stimulus: d_addr changes during BUSY.
  - Required: mem_addr stays at the latched value.
- Reset mid-access:
  - Stimulus: reset asserted during BUSY, then a late mem_done.
  - Required: mem_start = 0 and grant = 00 after the edge; no done pulse; the late mem_done is ignored.
- Timeout (MEM_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES = 4):
  - Stimulus: no mem_done.
  - Required: done pulses after 4 BUSY cycles with rdata = 0; err = 1 until reset.
